// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing source: pixel tick, x/y counters, syncs and frame-advance pulse
module vga_sync_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int TICK_DIV   = 2,
    parameter int UPDATE_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       update_signal
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(UPDATE_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] frame_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          frame_event;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            p_tick   <= 1'b0;
        end else begin
            p_tick   <= (tick_cnt == TICK_LAST);
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end
    end

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = 10'd0;
                v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Entering vertical blank marks the end of the drawn frame.
    assign frame_event = p_tick && (h_next == 10'd0) && (v_next == V_VIS);

    // Syncs come from the next-state counters so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt         <= 10'd0;
            v_cnt         <= 10'd0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            frame_cnt     <= '0;
            update_signal <= 1'b0;
        end else begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            hsync         <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync         <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            update_signal <= frame_event && (frame_cnt == FRAME_LAST) && !pause;
            if (frame_event) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
            end
        end
    end

    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - checks two reduced-geometry vga_sync_gen instances against a pixel-index model
module tb_vga_sync_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       upd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pause = 1'b0;

    logic       a_pt, a_von, a_hs, a_vs, a_upd;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_von, b_hs, b_vs, b_upd;
    logic [9:0] b_x, b_y;

    int total = 0;
    int bad = 0;
    int k;
    logic last_pause;
    int a_upd_q[$], b_upd_q[$], a_hsf_q[$], a_hsr_q[$], b_vsf_q[$], b_vsr_q[$];
    logic prev_a_hs = 1'b1, prev_b_vs = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .TICK_DIV(2), .UPDATE_DIV(3)) dut_a (
        .clk(clk), .reset(rst_n), .pause(pause), .p_tick(a_pt),
        .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von),
        .hsync(a_hs), .vsync(a_vs), .update_signal(a_upd));

    vga_sync_gen #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .TICK_DIV(1), .UPDATE_DIV(1)) dut_b (
        .clk(clk), .reset(rst_n), .pause(pause), .p_tick(b_pt),
        .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von),
        .hsync(b_hs), .vsync(b_vs), .update_signal(b_upd));

    // Edges seen since reset release, and pause as seen by that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= 0;
            last_pause <= 1'b0;
        end else begin
            k          <= k + 1;
            last_pause <= pause;
        end
    end

    // Outputs after edge n depend only on the pixel index floor((n-1)/d).
    function automatic exp_t model(input int n, input int d, input int u, input logic pz);
        exp_t e;
        int p, x, y, ev_no;
        logic adv;
        p = (n >= 1) ? (n - 1) / d : 0;
        x = p % HT;
        y = (p / HT) % VT;
        adv = (n >= 2) && ((n - 1) % d == 0);
        e.pt  = (n >= 1) && (n % d == 0);
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.von = (x < HD) && (y < VD);
        e.hs  = !((x >= HD + HF) && (x <= HD + HF + HS - 1));
        e.vs  = !((y >= VD + VF) && (y <= VD + VF + VS - 1));
        e.upd = 1'b0;
        if (adv && (p % FR == VD * HT)) begin
            ev_no = (p - VD * HT) / FR + 1;
            e.upd = (ev_no % u == 0) && !pz;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (k=%0d)", name, act, req, k);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(k, 2, 3, last_pause);
        eb = model(k, 1, 1, last_pause);
        chk("a_p_tick", int'(a_pt), int'(ea.pt));
        chk("a_pixel_x", int'(a_x), int'(ea.x));
        chk("a_pixel_y", int'(a_y), int'(ea.y));
        chk("a_video_on", int'(a_von), int'(ea.von));
        chk("a_hsync", int'(a_hs), int'(ea.hs));
        chk("a_vsync", int'(a_vs), int'(ea.vs));
        chk("a_update", int'(a_upd), int'(ea.upd));
        chk("b_p_tick", int'(b_pt), int'(eb.pt));
        chk("b_pixel_x", int'(b_x), int'(eb.x));
        chk("b_pixel_y", int'(b_y), int'(eb.y));
        chk("b_video_on", int'(b_von), int'(eb.von));
        chk("b_hsync", int'(b_hs), int'(eb.hs));
        chk("b_vsync", int'(b_vs), int'(eb.vs));
        chk("b_update", int'(b_upd), int'(eb.upd));
        if (a_upd) a_upd_q.push_back(k);
        if (b_upd) b_upd_q.push_back(k);
        if (prev_a_hs && !a_hs) a_hsf_q.push_back(k);
        if (!prev_a_hs && a_hs) a_hsr_q.push_back(k);
        if (prev_b_vs && !b_vs) b_vsf_q.push_back(k);
        if (!prev_b_vs && b_vs) b_vsr_q.push_back(k);
        prev_a_hs = a_hs;
        prev_b_vs = b_vs;
    end

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k < target) chk("run_to_timeout", k, target);
        #2;
    endtask

    task automatic clear_queues();
        a_upd_q.delete(); b_upd_q.delete();
        a_hsf_q.delete(); a_hsr_q.delete();
        b_vsf_q.delete(); b_vsr_q.delete();
    endtask

    initial begin
        int cnt, found;
        repeat (5) @(negedge clk);
        #2;
        chk("rst_a_hsync", int'(a_hs), 1);
        chk("rst_a_vsync", int'(a_vs), 1);
        chk("rst_a_update", int'(a_upd), 0);
        chk("rst_a_p_tick", int'(a_pt), 0);
        chk("rst_a_pixel_x", int'(a_x), 0);
        chk("rst_a_pixel_y", int'(a_y), 0);
        chk("rst_a_video_on", int'(a_von), 1);
        chk("rst_b_hsync", int'(b_hs), 1);
        chk("rst_b_vsync", int'(b_vs), 1);
        chk("rst_b_update", int'(b_upd), 0);

        @(negedge clk); #1 rst_n = 1'b1;
        run_to(900);
        chk("b_first_update_k", qat(b_upd_q, 0), 91);
        chk("b_update_spacing", qat(b_upd_q, 1) - qat(b_upd_q, 0), FR);
        chk("a_update_count", a_upd_q.size(), 1);
        chk("a_first_update_k", qat(a_upd_q, 0), 841);
        chk("a_first_hsync_fall_k", qat(a_hsf_q, 0), 21);
        chk("a_line_period", qat(a_hsf_q, 1) - qat(a_hsf_q, 0), 2 * HT);
        chk("a_hsync_low_width", qat(a_hsr_q, 0) - qat(a_hsf_q, 0), 2 * HS);
        chk("b_first_vsync_fall_k", qat(b_vsf_q, 0), 106);
        chk("b_vsync_low_width", qat(b_vsr_q, 0) - qat(b_vsf_q, 0), VS * HT);

        pause = 1'b1;
        run_to(1000);
        pause = 1'b0;
        run_to(1260);
        cnt = 0;
        found = 0;
        foreach (b_upd_q[i]) begin
            if (b_upd_q[i] > 900 && b_upd_q[i] <= 1000) cnt++;
            if (b_upd_q[i] == 1081 || b_upd_q[i] == 1246) found++;
        end
        chk("b_paused_pulses", cnt, 0);
        chk("b_pulses_after_pause", found, 2);

        #1 rst_n = 1'b0;
        #1;
        chk("midrst_b_pixel_x", int'(b_x), 0);
        chk("midrst_b_pixel_y", int'(b_y), 0);
        chk("midrst_a_p_tick", int'(a_pt), 0);
        chk("midrst_a_hsync", int'(a_hs), 1);
        repeat (3) @(negedge clk);
        clear_queues();
        #1 rst_n = 1'b1;
        run_to(900);
        chk("post_rst_b_first_update", qat(b_upd_q, 0), VD * HT + 1);
        chk("post_rst_a_first_update", qat(a_upd_q, 0), 841);
        chk("post_rst_a_hsync_fall", qat(a_hsf_q, 0), 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
